// File: rtl/occupancy_scanout.sv
// VGA scan-out of the 1-bit occupancy grid: generates timing from a pixel-rate enable,
// fetches each visible pixel's cell bit, and drives colour, syncs and the per-frame buffer swap.
module occupancy_scanout #(
    parameter int          GRID_W     = 32,
    parameter int          GRID_H     = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          CELL_SHIFT = 4,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter logic [11:0] OUT_COLOR  = 12'h222,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  frame_swap,
    output logic                  hsync,
    output logic                  vsync,
    output logic [11:0]           vga_rgb,
    output logic [7:0]            frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [31:0] H_ACT_U  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_U  = 32'(V_ACTIVE);
    localparam logic [31:0] HS_BEG_U = 32'(H_ACTIVE + H_FRONT);
    localparam logic [31:0] HS_END_U = 32'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [31:0] VS_BEG_U = 32'(V_ACTIVE + V_FRONT);
    localparam logic [31:0] VS_END_U = 32'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [31:0] GRID_W_U = 32'(GRID_W);
    localparam logic [31:0] GRID_H_U = 32'(GRID_H);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // Swap fires on the pixel step that enters the first blanking line, never inside active video.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_swap  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_swap <= 1'b0;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                    if (v_cnt == VW'(V_ACTIVE - 1)) begin
                        frame_swap  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    logic [31:0]           h_ext, v_ext, cell_x, cell_y;
    logic                  active_c, in_grid_c, hs_raw_c, vs_raw_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    always_comb begin
        h_ext     = 32'(h_cnt);
        v_ext     = 32'(v_cnt);
        cell_x    = h_ext >> CELL_SHIFT;
        cell_y    = v_ext >> CELL_SHIFT;
        active_c  = (h_ext < H_ACT_U) && (v_ext < V_ACT_U);
        in_grid_c = active_c && (cell_x < GRID_W_U) && (cell_y < GRID_H_U);
        hs_raw_c  = !((h_ext >= HS_BEG_U) && (h_ext < HS_END_U));
        vs_raw_c  = !((v_ext >= VS_BEG_U) && (v_ext < VS_END_U));
        addr_c    = ADDR_WIDTH'(cell_y * GRID_W_U + cell_x);
    end

    // Three free-running stages; read_data arrives one clk after read_addr, alongside stage 2.
    logic s1_active, s1_in_grid, s1_hs, s1_vs;
    logic s2_active, s2_in_grid, s2_hs, s2_vs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_addr  <= '0;
            s1_active  <= 1'b0;
            s1_in_grid <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s2_active  <= 1'b0;
            s2_in_grid <= 1'b0;
            s2_hs      <= 1'b1;
            s2_vs      <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            vga_rgb    <= 12'h000;
        end else begin
            if (in_grid_c) begin
                read_addr <= addr_c;
            end
            s1_active  <= active_c;
            s1_in_grid <= in_grid_c;
            s1_hs      <= hs_raw_c;
            s1_vs      <= vs_raw_c;
            s2_active  <= s1_active;
            s2_in_grid <= s1_in_grid;
            s2_hs      <= s1_hs;
            s2_vs      <= s1_vs;
            hsync      <= s2_hs;
            vsync      <= s2_vs;
            // read_data is only consulted for in-grid pixels, so a stale or unknown bit elsewhere is masked.
            if (!s2_active) begin
                vga_rgb <= 12'h000;
            end else if (!s2_in_grid) begin
                vga_rgb <= OUT_COLOR;
            end else if (read_data) begin
                vga_rgb <= FG_COLOR;
            end else begin
                vga_rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_occupancy_scanout.sv
// Bench for occupancy_scanout: a shrunken-timing instance checked cycle by cycle against a screen-coordinate
// model through an expected queue, plus a default-timing instance checked over its first scan line.
module tb_occupancy_scanout;

    // Small timing: 12x8 visible of 16x11 total, 2x2-pixel cells, 4x8 grid (rows 4..7 never visible).
    localparam int S_HT = 16;
    localparam int S_VT = 11;
    localparam int S_HA = 12;
    localparam int S_VA = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic [4:0]  addr_s;
    logic        rd_s;
    logic        swap_s, hs_s, vs_s;
    logic [11:0] rgb_s;
    logic [7:0]  fc_s;

    logic        rst_big = 1'b1;
    logic        pix_en_big = 1'b1;
    logic [9:0]  addr_big;
    logic        rd_big = 1'b0;
    logic        swap_big, hs_big, vs_big;
    logic [11:0] rgb_big;
    logic [7:0]  fc_big;

    always #5 clk = ~clk;

    occupancy_scanout #(
        .GRID_W(4), .GRID_H(8), .ADDR_WIDTH(5), .CELL_SHIFT(1),
        .FG_COLOR(12'hF80), .BG_COLOR(12'h00F), .OUT_COLOR(12'h222),
        .H_ACTIVE(12), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_dut (
        .clk(clk), .reset(rst), .pix_en(pix_en), .read_addr(addr_s), .read_data(rd_s),
        .frame_swap(swap_s), .hsync(hs_s), .vsync(vs_s), .vga_rgb(rgb_s), .frame_count(fc_s)
    );

    occupancy_scanout u_big (
        .clk(clk), .reset(rst_big), .pix_en(pix_en_big), .read_addr(addr_big), .read_data(rd_big),
        .frame_swap(swap_big), .hsync(hs_big), .vsync(vs_big), .vga_rgb(rgb_big), .frame_count(fc_big)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (small instance) ----------------
    logic        mem_s [0:31];
    logic [13:0] exp_q[$];
    int          px, py;
    logic        ig_prev;
    logic        exp_swap;
    logic [7:0]  exp_fc;
    logic        model_en = 1'b0;
    logic        mon_en   = 1'b0;
    int          swap_cnt = 0;

    function automatic logic in_grid_s(input int x, input int y);
        return (x < S_HA) && (y < S_VA) && ((x >> 1) < 4) && ((y >> 1) < 8);
    endfunction

    function automatic logic [13:0] exp_s(input int x, input int y);
        logic        hs, vs;
        logic [11:0] c;
        hs = !(x >= 13 && x < 15);
        vs = !(y == 9);
        if (!(x < S_HA && y < S_VA)) c = 12'h000;
        else if (!in_grid_s(x, y)) c = 12'h222;
        else c = mem_s[(y >> 1) * 4 + (x >> 1)] ? 12'hF80 : 12'h00F;
        return {hs, vs, c};
    endfunction

    // RAM with one-clk read latency; it returns X for any address fetched for an off-grid pixel.
    always @(posedge clk) begin
        if (model_en) begin
            rd_s <= ig_prev ? mem_s[addr_s] : 1'bx;
            ig_prev = in_grid_s(px, py);
            exp_swap = 1'b0;
            if (pix_en) begin
                if (px == S_HT - 1) begin
                    px = 0;
                    if (py == S_VA - 1) begin
                        exp_swap = 1'b1;
                        exp_fc = exp_fc + 8'd1;
                    end
                    py = (py == S_VT - 1) ? 0 : py + 1;
                end else begin
                    px = px + 1;
                end
            end
            exp_q.push_back(exp_s(px, py));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [13:0] e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: no expected pixel queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 32'({hs_s, vs_s, rgb_s}), 32'(e));
            end
            check("frame_swap", 32'(swap_s), 32'(exp_swap));
            check("frame_count", 32'(fc_s), 32'(exp_fc));
            check("addr_visible", 32'(addr_s <= 5'd15), 32'd1);
            if (swap_s) swap_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset(input int hold, input int mem_mode);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_en = 1'b0;
        mon_en = 1'b0;
        #1;
        check("rst_hsync", 32'(hs_s), 32'd1);
        check("rst_vsync", 32'(vs_s), 32'd1);
        check("rst_rgb", 32'(rgb_s), 32'd0);
        check("rst_swap", 32'(swap_s), 32'd0);
        check("rst_fcount", 32'(fc_s), 32'd0);
        check("rst_addr", 32'(addr_s), 32'd0);
        for (int i = 0; i < 32; i++) begin
            case (mem_mode)
                0: mem_s[i] = (i == 0);
                2: mem_s[i] = (i == 31);
                default: mem_s[i] = 1'($urandom_range(0, 1));
            endcase
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        px = 0;
        py = 0;
        ig_prev = 1'b0;
        exp_swap = 1'b0;
        exp_fc = 8'd0;
        exp_q.delete();
        exp_q.push_back(14'h3000);
        exp_q.push_back(14'h3000);
        exp_q.push_back(exp_s(0, 0));
        #1;
        model_en = 1'b1;
        mon_en = 1'b1;
    endtask

    // mode 0: every 4th clk, 1: random, 2: held high, 3: held low
    task automatic drive(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (mode)
                0: pix_en = (i % 4 == 0);
                1: pix_en = ($urandom_range(0, 2) == 0);
                2: pix_en = 1'b1;
                default: pix_en = 1'b0;
            endcase
        end
    endtask

    // ---------------- default-timing instance: first scan line ----------------
    logic big_done = 1'b0;

    always @(posedge clk) rd_big <= (addr_big == 10'd5);

    function automatic logic [13:0] exp_big(input int k);
        int          j, x, y;
        logic        hs;
        logic [11:0] c;
        if (k < 3) return 14'h3000;
        j = k - 3;
        x = j % 800;
        y = j / 800;
        hs = !(x >= 656 && x < 752);
        if (!(x < 640 && y < 480)) c = 12'h000;
        else if (x >= 512) c = 12'h222;
        else c = (((y >> 4) * 32 + (x >> 4)) == 5) ? 12'hFFF : 12'h000;
        return {hs, 1'b1, c};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst_big = 1'b0;
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            check("big_pixel", 32'({hs_big, vs_big, rgb_big}), 32'(exp_big(k)));
        end
        check("big_no_swap", 32'(swap_big), 32'd0);
        big_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int found;
        apply_reset(2, 0);
        drive(0, 720);

        apply_reset(2, 1);
        drive(1, 2000);
        drive(3, 20);
        drive(2, 300);
        drive(1, 500);

        apply_reset(2, 2);
        drive(0, 720);

        // Reset mid-line, mid-frame with pix_en high.
        apply_reset(2, 1);
        pix_en = 1'b1;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (px == 6 && py == 5) found = 1;
        end
        check("reach_mid_frame", 32'(found), 32'd1);
        apply_reset(2, 1);
        drive(1, 600);

        // 256 frames with pix_en tied high: frame_count must wrap to 0.
        pix_en = 1'b1;
        apply_reset(2, 1);
        swap_cnt = 0;
        repeat (256 * S_HT * S_VT) @(posedge clk);
        @(negedge clk);
        #2;
        check("wrap_fcount", 32'(fc_s), 32'd0);
        check("swap_pulses", 32'(swap_cnt), 32'd256);
        drive(1, 50);

        wait (big_done);
        mon_en = 1'b0;
        model_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
